// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, types and helpers for the FFT output reorder buffer.
package fft_out_reorder_pkg;

  localparam int unsigned N     = 32;
  localparam int unsigned LOG2N = 5;
  localparam int unsigned WIDTH = 9;

  // One complex sample, signed fixed-point (6,3) per component.
  typedef struct packed {
    logic signed [WIDTH-1:0] r;
    logic signed [WIDTH-1:0] i;
  } sample_t;

  typedef enum logic [0:0] {
    StIdle,
    StRead
  } rd_state_e;

  // Reverse the bit order of a frame index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] b;
    for (int unsigned k = 0; k < LOG2N; k++) begin
      b[k] = a[LOG2N-1-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/fft_reorder_mem.sv
// Two-bank frame store: one synchronous write port, one combinational read port.
module fft_reorder_mem
  import fft_out_reorder_pkg::*;
#(
  parameter int unsigned N     = fft_out_reorder_pkg::N,
  parameter int unsigned LOG2N = fft_out_reorder_pkg::LOG2N
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [LOG2N-1:0] waddr,
  input  sample_t          wdata,
  input  logic             rbank,
  input  logic [LOG2N-1:0] raddr,
  output sample_t          rdata
);

  // Bank select is the address MSB; contents are intentionally not reset.
  sample_t mem_q [2*N];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[{wbank, waddr}] <= wdata;
    end
  end

  assign rdata = mem_q[{rbank, raddr}];

endmodule

// File: rtl/fft_out_reorder.sv
// Restores natural order on bit-reversed SDF FFT frames using ping-pong banks.
// Writer fills one bank at bit-reversed addresses; reader streams the other
// bank in natural order through a valid/ready output register.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  // Must match the package constants (bitrev and sample_t are sized by them).
  parameter int unsigned N     = fft_out_reorder_pkg::N,
  parameter int unsigned LOG2N = fft_out_reorder_pkg::LOG2N,
  parameter int unsigned WIDTH = fft_out_reorder_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             overflow
);

  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  // Write side state
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q, full_d;

  // Read side state
  rd_state_e        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] raddr_q, raddr_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;
  logic [WIDTH-1:0] out_i_q, out_i_d;
  logic [LOG2N-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;

  logic    we;
  logic    wr_last;
  logic    rd_last;
  logic    adv;
  sample_t wr_sample;
  sample_t rd_sample;

  assign wr_sample.r = in_r;
  assign wr_sample.i = in_i;

  fft_reorder_mem #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .wbank (wbank_q),
    .waddr (bitrev(wcnt_q)),
    .wdata (wr_sample),
    .rbank (rbank_q),
    .raddr (raddr_q),
    .rdata (rd_sample)
  );

  // Write side: accept into the current bank unless it still holds an unread frame.
  always_comb begin
    we       = in_valid && !full_q[wbank_q];
    overflow = in_valid && full_q[wbank_q];
    wr_last  = we && (wcnt_q == LastIdx);
    wcnt_d   = we ? wcnt_q + 1'b1 : wcnt_q;
    wbank_d  = wr_last ? ~wbank_q : wbank_q;
  end

  // Read side FSM and output register next-state.
  always_comb begin
    adv         = !out_valid_q || out_ready;
    state_d     = state_q;
    rbank_d     = rbank_q;
    raddr_d     = raddr_q;
    rd_last     = 1'b0;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      StIdle: begin
        if (adv) begin
          if (full_q[rbank_q]) begin
            // raddr_q is always 0 here; it wrapped after the previous frame.
            out_valid_d = 1'b1;
            out_r_d     = rd_sample.r;
            out_i_d     = rd_sample.i;
            out_idx_d   = raddr_q;
            out_last_d  = 1'b0;
            raddr_d     = raddr_q + 1'b1;
            state_d     = StRead;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      StRead: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_r_d     = rd_sample.r;
          out_i_d     = rd_sample.i;
          out_idx_d   = raddr_q;
          out_last_d  = (raddr_q == LastIdx);
          raddr_d     = raddr_q + 1'b1;
          if (raddr_q == LastIdx) begin
            // Bank fully consumed: release it so the writer can reuse it.
            rd_last = 1'b1;
            rbank_d = ~rbank_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full flags: reader clear first, writer set after, so a same-cycle pair never loses a frame.
  always_comb begin
    full_d = full_q;
    if (rd_last) full_d[rbank_q] = 1'b0;
    if (wr_last) full_d[wbank_q] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= StIdle;
      rbank_q     <= 1'b0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      raddr_q     <= raddr_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output end of the 32-point SDF FFT pipeline. The delay-feedback stages emit each frame in bit-reversed index order; this block restores natural order.
- Two ping-pong banks. The write side captures a frame at bit-reversed addresses. The read side streams the other bank in natural order through a valid/ready output register.
- Sits after the last butterfly stage and drives the system output.

Parameters:
- N, 32, points per frame (power of 2).
- LOG2N, 5, address width; must equal log2(N).
- WIDTH, 9, bits per real/imag component, signed fixed-point (6,3), passed through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present this cycle.
- in_r  in  WIDTH  real part, bit-reversed frame order.
- in_i  in  WIDTH  imag part.
- out_ready  in  1  downstream accepts output this cycle.
- out_valid  out  1  output register holds a valid sample.
- out_r  out  WIDTH  real part, natural order.
- out_i  out  WIDTH  imag part.
- out_idx  out  LOG2N  natural frequency index of the current output.
- out_last  out  1  high with out_idx == N-1.
- overflow  out  1  one-cycle pulse: input sample dropped.

Behaviour:
- Reset (async, rst=1): all outputs 0, wcnt=0, wbank=0, rbank=0, full[1:0]=0, reader IDLE. Bank memory contents are not reset.
- Write side:
  - Accept when in_valid=1 and full[wbank]=0. Write {in_r,in_i} to bank wbank at address bitrev(wcnt); wcnt++.
  - On the write with wcnt==N-1: set full[wbank], wcnt wraps to 0, wbank toggles.
  - Gaps in in_valid are allowed; wcnt simply holds.
- Write overflow: in_valid=1 while full[wbank]=1 drops the sample. wcnt is unchanged and overflow=1 for that cycle.
- Read side FSM, states IDLE and READ.
  - Output register advance condition: adv = !out_valid || out_ready.
  - IDLE: if full[rbank] and adv, load entry 0 of rbank into the output register, set out_valid=1, out_idx=0, go to READ with raddr=1.
  - READ: on adv, load entry raddr; out_idx=raddr; out_last=(raddr==N-1); raddr++.
  - The adv that loads entry N-1 also clears full[rbank] and toggles rbank.
  - Next cycle after that: if full[new rbank], continue with entry 0 with no bubble. Otherwise the output holds until accepted, then out_valid drops and the FSM returns to IDLE.
  - out_valid/out_r/out_i/out_idx/out_last are stable while out_valid=1 and out_ready=0.
- Latency: the first out_valid rises on the first rising edge after the edge that writes the frame's N-th sample.
- Throughput: with back-to-back frames and out_ready=1, output is continuous at 1 sample/cycle.
- Simultaneous set/clear of full flags: full[b] set by the write side and full[b'] cleared by the read side in the same cycle are both honoured (b≠b' by construction). If both target the same bank, the clear applies to the old frame and the set applies after it, i.e. full stays 1 and no frame is lost.
- Reset mid-frame: a partially written frame and any unread bank are discarded. out_valid drops immediately.
- Arithmetic: none; data is bit-exact passthrough.

Decomposition:
- Shared package: constants N and LOG2N; a bitrev function of width LOG2N; the sample struct {r,i} of WIDTH each.
- One sub-module, fft_reorder_mem: 2×N×(2·WIDTH) storage with one write port (bank, addr, data, we) and one combinational read port (bank, addr). The FSM and counters stay in the top.

Test Plan:
- Identity order: after reset, drive 32 back-to-back samples j=0..31 with in_r=bitrev(j), in_i=-bitrev(j), out_ready=1. Expect out_valid high from 1 edge after the 32nd write for 32 cycles, out_r=0..31, out_i=0..-31, out_idx matching, out_last only at idx 31.
- Back-to-back frames: 3 consecutive frames (in_r offset by 0, 32, 64 mod 256 as 9-bit), out_ready=1. Expect 96 contiguous valid outputs with no bubble and correct ordering per frame.
- Backpressure: during readout, hold out_ready=0 for 5 cycles at idx 10. Expect outputs frozen at idx 10 and resuming at 11 with no loss or duplication.
- Overflow: out_ready=0 permanently, write 3 frames. Expect frames 1–2 accepted, overflow pulsing for all 32 samples of frame 3, then out_ready=1 yielding exactly frames 1 and 2.
- Input gaps: frame with in_valid toggling 1,0,1,0. Expect correct natural-order output, with first out_valid 1 edge after the 32nd valid sample.
- Mid-frame reset: assert rst after 17 samples, release, send a full frame. Expect outputs 0 during reset and only the new frame appearing, in correct order.
